// File: rtl/aes_job_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// aes_job_scheduler_pkg
// Shared types and defaults for the AES job scheduler.
//   text_t / key_t   : 128-bit AES block and key containers
//   sched_state_e    : scheduler FSM states
//   SCHED_NUM_REQ    : default number of requesters
//   SCHED_TIMEOUT    : default watchdog limit in cycles
// -----------------------------------------------------------------------------
package aes_job_scheduler_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int SCHED_NUM_REQ = 4;
  localparam int SCHED_TIMEOUT = 64;

  typedef logic [AES_BLOCK_W-1:0] text_t;
  typedef logic [AES_BLOCK_W-1:0] key_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } sched_state_e;

endpackage : aes_job_scheduler_pkg

// File: rtl/aes_job_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// aes_job_scheduler_rr_arbiter
// Purely combinational round-robin arbiter. Scans req starting at rr_ptr and
// wrapping modulo NUM_REQ; the first set bit wins. The pointer itself lives in
// the scheduler, so this block holds no state.
// Ports:
//   req       in  NUM_REQ  request vector
//   rr_ptr    in  ID_W     index that has highest priority this cycle
//   enable    in  1        grants are forced to zero when low
//   grant     out NUM_REQ  one-hot grant (all zero if nothing requested)
//   grant_idx out ID_W     binary index of the granted requester
// -----------------------------------------------------------------------------
module aes_job_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    logic found;
    int   idx;
    // NOTE: every signal written here gets a default first so no path
    // through the loop can infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule : aes_job_scheduler_rr_arbiter

// File: rtl/aes_job_scheduler.sv
// -----------------------------------------------------------------------------
// aes_job_scheduler
// Shares one AES-128 core between NUM_REQ requesters. A round-robin grant picks
// a request in IDLE, its plaintext/key are latched and handed to the core with a
// one-cycle start pulse, and the ciphertext comes back on a valid/ready response
// channel tagged with the requester index. A watchdog aborts a hung core and
// returns an error response with zero data instead.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester request handshake (ready is one-hot)
//   req_text/req_key        packed plaintexts/keys, slice i = requester i
//   core_start              single-cycle start to the core
//   core_text/core_key      latched operands, held from ISSUE through RESPOND
//   core_done/core_result   core completion pulse and ciphertext
//   rsp_valid/rsp_ready     response handshake
//   rsp_text/rsp_id         ciphertext (0 on error) and requester index
//   rsp_error               1 when the job was aborted by the watchdog
//   busy                    high whenever the FSM is not IDLE
// ID_W must equal $clog2(NUM_REQ).
// -----------------------------------------------------------------------------
module aes_job_scheduler
  import aes_job_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = SCHED_NUM_REQ,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = SCHED_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_text,
  input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_key,
  output logic                         core_start,
  output text_t                        core_text,
  output key_t                         core_key,
  input  logic                         core_done,
  input  text_t                        core_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output text_t                        rsp_text,
  output logic [ID_W-1:0]              rsp_id,
  output logic                         rsp_error,
  output logic                         busy
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  sched_state_e      state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  text_t             text_q, text_d;
  key_t              key_q, key_d;
  text_t             rsp_text_q, rsp_text_d;
  logic              rsp_error_q, rsp_error_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [WD_W-1:0]   wd_inc;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;

  aes_job_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .enable    (state_q == IDLE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    text_d      = text_q;
    key_d       = key_q;
    rsp_text_d  = rsp_text_q;
    rsp_error_d = rsp_error_q;
    wd_d        = wd_q;
    wd_inc      = wd_q + WD_W'(1);

    unique case (state_q)
      IDLE: begin
        // grant is already qualified by req_valid, so any set bit is a handshake
        if (|grant) begin
          text_d   = req_text[int'(grant_idx)*AES_BLOCK_W +: AES_BLOCK_W];
          key_d    = req_key[int'(grant_idx)*AES_BLOCK_W +: AES_BLOCK_W];
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_inc;
        // done is tested first so a completion on the final watchdog cycle
        // still returns good data. Aborting when the post-increment count hits
        // TIMEOUT_CYCLES-1 makes rsp_valid rise TIMEOUT_CYCLES cycles after
        // core_start.
        if (core_done) begin
          rsp_text_d  = core_result;
          rsp_error_d = 1'b0;
          state_d     = RESPOND;
        end else if (wd_inc == WD_W'(TIMEOUT_CYCLES-1)) begin
          rsp_text_d  = '0;
          rsp_error_d = 1'b1;
          state_d     = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the wide operand/result registers are reset here because their
      // contents drive output ports that must read zero out of reset.
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      text_q      <= '0;
      key_q       <= '0;
      rsp_text_q  <= '0;
      rsp_error_q <= 1'b0;
      wd_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      text_q      <= text_d;
      key_q       <= key_d;
      rsp_text_q  <= rsp_text_d;
      rsp_error_q <= rsp_error_d;
      wd_q        <= wd_d;
    end
  end

  assign req_ready  = grant;
  assign core_start = (state_q == ISSUE);
  assign core_text  = text_q;
  assign core_key   = key_q;
  assign rsp_valid  = (state_q == RESPOND);
  assign rsp_text   = rsp_text_q;
  assign rsp_id     = id_q;
  assign rsp_error  = rsp_error_q;
  assign busy       = (state_q != IDLE);

endmodule : aes_job_scheduler

// File: tb/tb_aes_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_aes_job_scheduler
// Randomized bench with a scoreboard. The driver predicts the round-robin
// service order of each batch of requests from the arbitration rule and pushes
// the expected responses; an independent monitor pops and compares whenever a
// response handshake occurs. A small core model answers core_start after a
// programmable latency (or never, to provoke the watchdog).
// -----------------------------------------------------------------------------
module tb_aes_job_scheduler;
  import aes_job_scheduler_pkg::*;

  localparam int NR = 4;
  localparam int IW = 2;
  localparam int TO = 64;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*128-1:0] req_text;
  logic [NR*128-1:0] req_key;
  logic              core_start;
  logic [127:0]      core_text;
  logic [127:0]      core_key;
  logic              core_done;
  logic [127:0]      core_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [127:0]      rsp_text;
  logic [IW-1:0]     rsp_id;
  logic              rsp_error;
  logic              busy;

  aes_job_scheduler #(
    .NUM_REQ        (NR),
    .ID_W           (IW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_text    (req_text),
    .req_key     (req_key),
    .core_start  (core_start),
    .core_text   (core_text),
    .core_key    (core_key),
    .core_done   (core_done),
    .core_result (core_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_text    (rsp_text),
    .rsp_id      (rsp_id),
    .rsp_error   (rsp_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Behaviour of the AES core seen by the scheduler: the FIPS-197 vector
  // gives the real ciphertext, anything else a cheap keyed scramble.
  function automatic logic [127:0] core_func(input logic [127:0] t, input logic [127:0] k);
    if (t == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return t ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  // ---------------------------------------------------------------- core model
  int           core_lat  = 10;
  bit           core_hang = 1'b0;
  int           core_cnt  = 0;
  logic [127:0] core_pend = '0;
  int           n_starts  = 0;
  int           last_start_cyc = 0;
  int           spur_cnt  = 0;
  int           spur_seen = 0;

  initial begin
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done   = 1'b1;
          core_result = core_pend;
        end
      end
      if (core_start) begin
        n_starts++;
        last_start_cyc = cyc;
        if (!core_hang) begin
          core_cnt  = core_lat;
          core_pend = core_func(core_text, core_key);
        end
      end
      if (spur_cnt != spur_seen) begin
        spur_seen   = spur_cnt;
        core_done   = 1'b1;
        core_result = rand128();
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    logic [IW-1:0] id;
    logic [127:0]  text;
    logic          err;
    int            lat;   // cycles from core_start to rsp_valid rising
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  bit   mon_prev_v = 1'b0;
  int   mon_rise_cyc = 0;
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        mon_prev_v = 1'b0;
        continue;
      end
      check("req_ready_onehot0", $onehot0(req_ready), 1);
      if (busy) check("req_ready_while_busy", req_ready, 0);
      if ((req_valid & req_ready) != '0) begin
        for (int i = 0; i < NR; i++) if (req_ready[i]) grant_log.push_back(i);
      end
      if (rsp_valid && !mon_prev_v) mon_rise_cyc = cyc;
      mon_prev_v = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_response: got id %0d text %h, nothing expected", rsp_id, rsp_text);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_id", rsp_id, mon_e.id);
          check("rsp_text", rsp_text, mon_e.text);
          check("rsp_error", rsp_error, mon_e.err);
          check("rsp_latency", mon_rise_cyc - last_start_cyc, mon_e.lat);
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  int            bp_mode  = 0;   // 0: ready high, 1: ready low, 2: random
  int            model_rr = 0;
  logic [NR-1:0] acc;

  // Advance one cycle: drop valid on requests accepted this cycle and update
  // rsp_ready. Called and returns at a falling edge.
  task automatic tick();
    #1;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
    case (bp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [127:0] t, input logic [127:0] k);
    req_text[r*128 +: 128] = t;
    req_key[r*128 +: 128]  = k;
  endtask

  task automatic push_exp(input int r, input int lat, input bit hang);
    exp_t e;
    e.id   = IW'(r);
    e.err  = hang;
    e.text = hang ? 128'd0 : core_func(req_text[r*128 +: 128], req_key[r*128 +: 128]);
    e.lat  = hang ? TO : lat + 1;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int budget = 0;
    while ((req_valid != '0 || exp_q.size() != 0) && budget < 3000) begin
      tick();
      budget++;
    end
    check(name, (req_valid == '0 && exp_q.size() == 0), 1);
  endtask

  // Raise every requester in mask at once; service order is the set bits in
  // cyclic order starting at the model's round-robin pointer.
  task automatic run_batch(input logic [NR-1:0] mask, input int lat, input bit hang, input bit rand_tk);
    int order[$];
    for (int i = 0; i < NR; i++) begin
      int r;
      r = (model_rr + i) % NR;
      if (mask[r]) order.push_back(r);
    end
    foreach (order[j]) begin
      if (rand_tk) set_req(order[j], rand128(), rand128());
      push_exp(order[j], lat, hang);
    end
    model_rr  = (order[order.size()-1] + 1) % NR;
    core_lat  = lat;
    core_hang = hang;
    req_valid = req_valid | mask;
    drain("batch_drained");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  req_ready, 0);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_core_text"},  core_text, 0);
    check({tag, "_core_key"},   core_key, 0);
    check({tag, "_rsp_valid"},  rsp_valid, 0);
    check({tag, "_rsp_text"},   rsp_text, 0);
    check({tag, "_rsp_id"},     rsp_id, 0);
    check({tag, "_rsp_error"},  rsp_error, 0);
    check({tag, "_busy"},       busy, 0);
  endtask

  // ---------------------------------------------------------------- sequence
  int           fair_exp[5] = '{0, 1, 2, 3, 0};
  logic [127:0] held;
  int           starts0;
  int           ra, rb, budget;

  initial begin
    req_valid = '0;
    req_text  = '0;
    req_key   = '0;
    rsp_ready = 1'b1;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Fairness from rr_ptr = 0: 0,1,2,3 then requester 0 again.
    grant_log.delete();
    run_batch(4'hF, 5, 1'b0, 1'b1);
    run_batch(4'h1, 5, 1'b0, 1'b1);
    check("fair_grant_count", grant_log.size(), 5);
    for (int i = 0; i < grant_log.size() && i < 5; i++) check("fair_grant_order", grant_log[i], fair_exp[i]);

    // FIPS-197 vector on requester 2, L = 10.
    set_req(2, FIPS_PT, FIPS_KEY);
    run_batch(4'b0100, 10, 1'b0, 1'b0);

    // Hung core, then a normal request.
    run_batch(4'b1000, 10, 1'b1, 1'b1);
    run_batch(4'b0011, 7, 1'b0, 1'b1);

    // Done on the final watchdog cycle wins; one cycle earlier is also good.
    run_batch(4'b0100, 63, 1'b0, 1'b1);
    run_batch(4'b0001, 62, 1'b0, 1'b1);

    // Backpressure with a spurious done while in RESPOND.
    bp_mode   = 1;
    core_lat  = 6;
    core_hang = 1'b0;
    ra = model_rr;
    rb = (ra + 2) % NR;
    set_req(ra, rand128(), rand128());
    set_req(rb, rand128(), rand128());
    push_exp(ra, 6, 1'b0);
    model_rr = (ra + 1) % NR;
    req_valid[ra] = 1'b1;
    budget = 0;
    while (!rsp_valid && budget < 100) begin
      tick();
      budget++;
    end
    check("bp_reached_respond", rsp_valid, 1);
    push_exp(rb, 6, 1'b0);
    model_rr = (rb + 1) % NR;
    req_valid[rb] = 1'b1;
    held    = rsp_text;
    starts0 = n_starts;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) spur_cnt++;
      tick();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_text_stable", rsp_text, held);
      check("bp_req_ready", req_ready, 0);
      check("bp_no_core_start", n_starts, starts0);
    end
    bp_mode = 0;
    drain("bp_drained");

    // Spurious done while IDLE.
    held    = rsp_text;
    starts0 = n_starts;
    spur_cnt++;
    repeat (4) tick();
    check("spur_idle_busy", busy, 0);
    check("spur_idle_rsp_valid", rsp_valid, 0);
    check("spur_idle_rsp_text", rsp_text, held);
    check("spur_idle_starts", n_starts, starts0);

    // Randomized batches with random backpressure.
    bp_mode = 2;
    for (int it = 0; it < 30; it++) begin
      if (it % 8 == 7) begin
        run_batch(NR'(1) << $urandom_range(0, NR-1), 10, 1'b1, 1'b1);
      end else begin
        run_batch(NR'($urandom_range(1, (1 << NR) - 1)),
                  ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(1, 20)),
                  1'b0, 1'b1);
      end
    end
    bp_mode = 0;
    tick();

    // Reset three cycles into WAIT; the late done must be ignored.
    core_lat  = 10;
    core_hang = 1'b0;
    set_req(3, rand128(), rand128());
    starts0 = n_starts;
    req_valid[3] = 1'b1;
    budget = 0;
    while (n_starts == starts0 && budget < 20) begin
      tick();
      budget++;
    end
    check("rst_job_started", n_starts, starts0 + 1);
    repeat (4) tick();
    check("rst_in_wait_busy", busy, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    reset_n  = 1'b1;
    model_rr = 0;
    starts0  = n_starts;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("rst_idle_busy", busy, 0);
      check("rst_idle_rsp_valid", rsp_valid, 0);
    end
    check("rst_late_done_text", rsp_text, 0);
    check("rst_no_core_start", n_starts, starts0);
    grant_log.delete();
    run_batch(4'hF, 4, 1'b0, 1'b1);
    check("rst_first_grant_count", grant_log.size() >= 1, 1);
    if (grant_log.size() >= 1) check("rst_rr_ptr_zero", grant_log[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule : tb_aes_job_scheduler
